// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the datapath: instruction/handshake
// inputs to the sequencer and every datapath strobe it drives.
interface control_sequencer_if #(
  parameter int ALUW = 5
);
  logic [31:0]     IR;
  logic            Mem_ready;
  logic            Stop;
  logic            Run;
  logic [ALUW-1:0] ALU_op;
  logic            PCout, IncPC, PC_enable, MAR_enable;
  logic            MDR_read, MDR_enable, MDRout, RAM_write;
  logic            IR_enable, Y_enable, ZLowIn, ZLowout;
  logic            Gra, Grb, Grc, R_in, R_out, BAout, Cout;

  modport master (
    input  IR, Mem_ready, Stop,
    output Run, ALU_op,
    output PCout, IncPC, PC_enable, MAR_enable,
    output MDR_read, MDR_enable, MDRout, RAM_write,
    output IR_enable, Y_enable, ZLowIn, ZLowout,
    output Gra, Grb, Grc, R_in, R_out, BAout, Cout
  );

  modport slave (
    output IR, Mem_ready, Stop,
    input  Run, ALU_op,
    input  PCout, IncPC, PC_enable, MAR_enable,
    input  MDR_read, MDR_enable, MDRout, RAM_write,
    input  IR_enable, Y_enable, ZLowIn, ZLowout,
    input  Gra, Grb, Grc, R_in, R_out, BAout, Cout
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit for the ld/ldi/st/ALU subset; decodes the latched
// opcode and drives datapath strobes, pacing memory reads on Mem_ready.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t         state_reg, state_next;
  logic [OPW-1:0] op_reg;

  logic is_ld, is_ldi, is_st, is_alu, is_imm, is_halt, is_mem;
  logic [OPW-1:0] imm_alu;

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_reg <= RST;
      op_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == T2)
        op_reg <= bus.IR[31:32-OPW];
    end
  end

  assign is_ld   = (op_reg == OPW'(0));
  assign is_ldi  = (op_reg == OPW'(1));
  assign is_st   = (op_reg == OPW'(2));
  assign is_alu  = (op_reg >= OPW'(3))  && (op_reg <= OPW'(10));
  assign is_imm  = (op_reg >= OPW'(11)) && (op_reg <= OPW'(13));
  assign is_halt = (op_reg == OPW'(26));
  assign is_mem  = is_ld || is_ldi || is_st;

  // addi/andi/ori reuse the add/and/or ALU functions
  always_comb begin
    imm_alu = OPW'(3);
    if (op_reg == OPW'(12)) imm_alu = OPW'(9);
    if (op_reg == OPW'(13)) imm_alu = OPW'(10);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST:  state_next = T0;
      T0:   state_next = T1;
      T1:   state_next = bus.Mem_ready ? T2 : T1;
      T2:   state_next = T3;
      T3: begin
        if (is_halt)                state_next = HALT;
        else if (is_mem || is_alu || is_imm) state_next = T4;
        else                        state_next = bus.Stop ? HALT : T0;
      end
      T4:   state_next = T5;
      T5:   state_next = (is_ld || is_st) ? T6 : (bus.Stop ? HALT : T0);
      T6:   state_next = (is_st || bus.Mem_ready) ? T7 : T6;
      T7:   state_next = bus.Stop ? HALT : T0;
      HALT: state_next = HALT;
      default: state_next = RST;
    endcase
  end

  always_comb begin
    bus.Run        = 1'b0;
    bus.ALU_op     = '0;
    bus.PCout      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.PC_enable  = 1'b0;
    bus.MAR_enable = 1'b0;
    bus.MDR_read   = 1'b0;
    bus.MDR_enable = 1'b0;
    bus.MDRout     = 1'b0;
    bus.RAM_write  = 1'b0;
    bus.IR_enable  = 1'b0;
    bus.Y_enable   = 1'b0;
    bus.ZLowIn     = 1'b0;
    bus.ZLowout    = 1'b0;
    bus.Gra        = 1'b0;
    bus.Grb        = 1'b0;
    bus.Grc        = 1'b0;
    bus.R_in       = 1'b0;
    bus.R_out      = 1'b0;
    bus.BAout      = 1'b0;
    bus.Cout       = 1'b0;
    case (state_reg)
      T0: begin
        bus.Run = 1'b1;
        bus.PCout = 1'b1; bus.MAR_enable = 1'b1; bus.IncPC = 1'b1; bus.ZLowIn = 1'b1;
      end
      T1: begin
        bus.Run = 1'b1;
        bus.MDR_read = 1'b1; bus.MDR_enable = 1'b1; bus.ZLowout = 1'b1;
        // PC loads only on the cycle T1 actually exits, so a stalled fetch
        // cannot advance PC more than once.
        bus.PC_enable = bus.Mem_ready;
      end
      T2: begin
        bus.Run = 1'b1;
        bus.MDRout = 1'b1; bus.IR_enable = 1'b1;
      end
      T3: begin
        bus.Run = 1'b1;
        if (is_mem) begin
          bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Y_enable = 1'b1;
        end else if (is_alu || is_imm) begin
          bus.Grb = 1'b1; bus.R_out = 1'b1; bus.Y_enable = 1'b1;
        end
      end
      T4: begin
        bus.Run = 1'b1;
        bus.ZLowIn = 1'b1;
        if (is_alu) begin
          bus.Grc = 1'b1; bus.R_out = 1'b1;
          bus.ALU_op = ALUW'(op_reg);
        end else if (is_imm) begin
          bus.Cout = 1'b1;
          bus.ALU_op = ALUW'(imm_alu);
        end else begin
          bus.Cout = 1'b1;
          bus.ALU_op = ALUW'(3);
        end
      end
      T5: begin
        bus.Run = 1'b1;
        bus.ZLowout = 1'b1;
        if (is_ld || is_st) bus.MAR_enable = 1'b1;
        else begin
          bus.Gra = 1'b1; bus.R_in = 1'b1;
        end
      end
      T6: begin
        bus.Run = 1'b1;
        bus.MDR_enable = 1'b1;
        if (is_st) begin
          bus.Gra = 1'b1; bus.R_out = 1'b1;
        end else bus.MDR_read = 1'b1;
      end
      T7: begin
        bus.Run = 1'b1;
        if (is_st) bus.RAM_write = 1'b1;
        else begin
          bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.R_in = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch and each instruction class
// through its T-states and compares the full strobe/ALU_op vector every cycle.
module tb_control_sequencer;
  logic Clock = 1'b0;
  logic Clear;
  int   n_checks = 0;
  int   n_pass   = 0;

  control_sequencer_if #(.ALUW(5)) bus ();

  control_sequencer #(.OPW(5), .ALUW(5)) dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  localparam logic [19:0] RUN = 20'h80000, PCO = 20'h40000, INC = 20'h20000,
                          PCE = 20'h10000, MAR = 20'h08000, MRD = 20'h04000,
                          MDE = 20'h02000, MDO = 20'h01000, RW  = 20'h00800,
                          IRE = 20'h00400, YE  = 20'h00200, ZI  = 20'h00100,
                          ZO  = 20'h00080, GA  = 20'h00040, GB  = 20'h00020,
                          GC  = 20'h00010, RI  = 20'h00008, RO  = 20'h00004,
                          BA  = 20'h00002, CO  = 20'h00001;
  localparam logic [19:0] T0M = RUN | PCO | MAR | INC | ZI;

  function automatic logic [31:0] obs();
    return {7'd0, bus.ALU_op, bus.Run, bus.PCout, bus.IncPC, bus.PC_enable,
            bus.MAR_enable, bus.MDR_read, bus.MDR_enable, bus.MDRout, bus.RAM_write,
            bus.IR_enable, bus.Y_enable, bus.ZLowIn, bus.ZLowout, bus.Gra, bus.Grb,
            bus.Grc, bus.R_in, bus.R_out, bus.BAout, bus.Cout};
  endfunction

  function automatic logic [31:0] ex(input logic [19:0] m, input logic [4:0] a);
    return {7'd0, a, m};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Starts in T0; ends in T2 with IR loaded.
  task automatic fetch(input string name, input logic [31:0] ir);
    $display("txn %s ir=%h", name, ir);
    bus.IR = ir;
    bus.Mem_ready = 1'b1;
    step(); check({name, "_T1"}, obs(), ex(RUN | MRD | MDE | ZO | PCE, 5'd0));
    step(); check({name, "_T2"}, obs(), ex(RUN | MDO | IRE, 5'd0));
  endtask

  initial begin
    Clear = 1'b0;
    bus.IR = 32'h0;
    bus.Mem_ready = 1'b0;
    bus.Stop = 1'b0;
    step(); step();
    check("reset", obs(), ex(20'h0, 5'd0));
    Clear = 1'b1;
    step(); check("first_T0", obs(), ex(T0M, 5'd0));

    // ld R1,2(R2) with a one-cycle memory stall in T6
    fetch("ld", 32'h00900002);
    step(); check("ld_T3", obs(), ex(RUN | GB | BA | YE, 5'd0));
    step(); check("ld_T4", obs(), ex(RUN | CO | ZI, 5'd3));
    step(); check("ld_T5", obs(), ex(RUN | ZO | MAR, 5'd0));
    bus.Mem_ready = 1'b0;
    step(); check("ld_T6a", obs(), ex(RUN | MRD | MDE, 5'd0));
    step(); check("ld_T6b", obs(), ex(RUN | MRD | MDE, 5'd0));
    bus.Mem_ready = 1'b1;
    step(); check("ld_T7", obs(), ex(RUN | MDO | GA | RI, 5'd0));
    step(); check("ld_T0", obs(), ex(T0M, 5'd0));

    // add with T1 stalled three cycles
    $display("txn add_stall ir=%h", 32'h19000000);
    bus.IR = 32'h19000000;
    bus.Mem_ready = 1'b0;
    step(); check("stall_T1a", obs(), ex(RUN | MRD | MDE | ZO, 5'd0));
    step(); check("stall_T1b", obs(), ex(RUN | MRD | MDE | ZO, 5'd0));
    step(); check("stall_T1c", obs(), ex(RUN | MRD | MDE | ZO, 5'd0));
    bus.Mem_ready = 1'b1;
    #1 check("stall_T1d", obs(), ex(RUN | MRD | MDE | ZO | PCE, 5'd0));
    step(); check("add_T2", obs(), ex(RUN | MDO | IRE, 5'd0));
    step(); check("add_T3", obs(), ex(RUN | GB | RO | YE, 5'd0));
    step(); check("add_T4", obs(), ex(RUN | GC | RO | ZI, 5'd3));
    step(); check("add_T5", obs(), ex(RUN | ZO | GA | RI, 5'd0));
    step(); check("add_T0", obs(), ex(T0M, 5'd0));

    // ori: immediate form maps to the or function 01010
    fetch("ori", 32'h68000000);
    step(); check("ori_T3", obs(), ex(RUN | GB | RO | YE, 5'd0));
    step(); check("ori_T4", obs(), ex(RUN | CO | ZI, 5'd10));
    step(); check("ori_T5", obs(), ex(RUN | ZO | GA | RI, 5'd0));
    step(); check("ori_T0", obs(), ex(T0M, 5'd0));

    // st: T6 ignores Mem_ready
    fetch("st", 32'h10000000);
    step(); check("st_T3", obs(), ex(RUN | GB | BA | YE, 5'd0));
    step(); check("st_T4", obs(), ex(RUN | CO | ZI, 5'd3));
    bus.Mem_ready = 1'b0;
    step(); check("st_T5", obs(), ex(RUN | ZO | MAR, 5'd0));
    step(); check("st_T6", obs(), ex(RUN | GA | RO | MDE, 5'd0));
    step(); check("st_T7", obs(), ex(RUN | RW, 5'd0));
    step(); check("st_T0", obs(), ex(T0M, 5'd0));

    // nop: single empty T3
    fetch("nop", 32'hC8000000);
    step(); check("nop_T3", obs(), ex(RUN, 5'd0));
    step(); check("nop_T0", obs(), ex(T0M, 5'd0));

    // ld aborted by Clear during T4
    fetch("ld_clear", 32'h00900002);
    step(); check("ldc_T3", obs(), ex(RUN | GB | BA | YE, 5'd0));
    step(); check("ldc_T4", obs(), ex(RUN | CO | ZI, 5'd3));
    Clear = 1'b0;
    #1 check("ldc_async", obs(), ex(20'h0, 5'd0));
    step(); check("ldc_held", obs(), ex(20'h0, 5'd0));
    Clear = 1'b1;
    step(); check("ldc_T0", obs(), ex(T0M, 5'd0));

    // ld with Stop at its boundary
    fetch("ld_stop", 32'h00900002);
    step(); step(); step(); step();
    check("lds_T6", obs(), ex(RUN | MRD | MDE, 5'd0));
    step(); check("lds_T7", obs(), ex(RUN | MDO | GA | RI, 5'd0));
    bus.Stop = 1'b1;
    step(); check("lds_halt", obs(), ex(20'h0, 5'd0));
    bus.Stop = 1'b0;
    step(); check("lds_halt_hold", obs(), ex(20'h0, 5'd0));
    Clear = 1'b0;
    step();
    Clear = 1'b1;
    step(); check("lds_T0", obs(), ex(T0M, 5'd0));

    // halt instruction
    fetch("halt", 32'hD0000000);
    step(); check("halt_T3", obs(), ex(RUN, 5'd0));
    step(); check("halt_state", obs(), ex(20'h0, 5'd0));
    step(); check("halt_hold", obs(), ex(20'h0, 5'd0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
